apb5_completer_regbank: RTL
===========================

Name: apb5_completer_regbank

Overview:
- APB5 completer (slave) with a small word-addressed register bank.
- Answers transfers issued by the APB master and is instantiated behind the decoder as the slave at BASE_ADDR.
- Programmable wait states, byte strobes, per-word user bits and PSLVERR on illegal access.
- Serves as the reference responder for master verification and as the template for future peripherals.

Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width (multiple of 8)
- USER_DATA_WIDTH, DATA_WIDTH/2, PWUSER/PRUSER width
- USER_RESP_WIDTH, 16, PBUSER width
- DEPTH, 16, number of words (power of 2, >=2)
- BASE_ADDR, 32'h0000_3000, first byte address decoded (aligned to DEPTH*4)
- WAIT_CYCLES, 1, access-phase wait states inserted before PREADY (0..15)
- ID_VALUE, 32'hA9B5_0001, read-only contents of word 0

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESET  in  1  synchronous reset, active-high
- PSEL  in  1  completer select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte strobes
- PPROT  in  3  protection (bit1=non-secure)
- PWUSER  in  USER_DATA_WIDTH  write user bits
- PREADY  out  1  transfer complete
- PRDATA  out  DATA_WIDTH  read data
- PSLVERR  out  1  error response, valid only with PREADY
- PRUSER  out  USER_DATA_WIDTH  read user bits
- PBUSER  out  USER_RESP_WIDTH  response user bits = error code

Behaviour:
- Reset (PRESET high at an edge): FSM to IDLE, counter 0, all bank words and user words 0.
- Outputs are 0 during reset and whenever PREADY=0: PREADY, PRDATA, PSLVERR, PRUSER, PBUSER.
- FSM IDLE: a setup phase (PSEL=1, PENABLE=0) at an edge does the following:
  - latch PADDR, PWRITE, PSTRB, PPROT, PWDATA, PWUSER
  - compute the error code
  - load cnt=WAIT_CYCLES
  - go to ACCESS
- FSM ACCESS:
  - PREADY = PSEL & PENABLE & (cnt==0), combinational from registered state.
  - At each edge with PSEL & PENABLE & cnt!=0: cnt decrements.
  - Completion edge (PREADY=1): go to IDLE.
  - PSEL=0 in ACCESS (abort): go to IDLE, no write, no response.
- Latency: PREADY rises in access cycle WAIT_CYCLES+1. With WAIT_CYCLES=0, a transfer is 2 cycles.
- Back-to-back: the next setup phase occurs the cycle after completion. It is sampled in IDLE, so there are no dead cycles beyond the APB minimum.
- Changes to PADDR/PWDATA during ACCESS are ignored; latched values are used.
- Error codes, in priority order (PBUSER[3:0]; upper bits 0):
  - 1: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH)
  - 2: PADDR[1:0]!=0
  - 3: write to word 0 (read-only ID)
  - 4: write with PPROT[1]=1 to the upper half of the bank (secure-only)
  - 0: OK
- PSLVERR = PREADY & (code!=0).
- Write commit on the completion edge, only if code==0:
  - byte lane i is updated iff PSTRB[i]
  - user word is replaced when any strobe is set
  - all strobes 0: no data change, OK response
- Read on completion: with code==0, PRDATA = bank[index] (word 0 returns ID_VALUE) and PRUSER = user[index]. With an error, PRDATA=0 and PRUSER=0.
- Index = (latched PADDR - BASE_ADDR) >> 2, width log2(DEPTH).
- Reset mid-transfer: transfer is dropped, no commit, PREADY=0 the next cycle.
- Reset has priority over every other event.

Decomposition:
- Shared package apb_pkg:
  - FSM state enum (IDLE, ACCESS)
  - error-code constants (ERR_OK, ERR_RANGE, ERR_ALIGN, ERR_RO, ERR_PROT)
  - strobe-width helper
- One sub-module, apb_regbank_mem: DEPTH x (DATA_WIDTH+USER_DATA_WIDTH) storage with byte-enable write and async read.
- FSM, decode and error logic live in the top.

Test Plan:
- Reset check: PRESET high 3 cycles, then release -> PREADY, PRDATA, PSLVERR all 0; read 0x3004 -> PRDATA=0, PSLVERR=0.
- Write 0x3008 = DEADBEEF, PSTRB=F, PWUSER=0x1234, WAIT_CYCLES=1 -> PREADY in 2nd access cycle; read back -> PRDATA=DEADBEEF, PRUSER=0x1234.
- Partial write 0x3008, PSTRB=4'b0010, PWDATA=0x0000AA00 -> readback DEADAAEF.
- Error cases (write unless noted):
  - 0x3040 -> PSLVERR=1, PBUSER=1
  - 0x3002 -> PBUSER=2
  - 0x3000 -> PBUSER=3, ID unchanged (read -> A9B50001)
  - 0x3020 with PPROT=3'b010 -> PBUSER=4, data unchanged
- Back-to-back write 0x3004 then read 0x3004, no idle between -> read returns written value; abort (PSEL drops in ACCESS) -> no write occurs.
- Assert PRESET during the wait state of a write to 0x300C -> no commit, PREADY=0 next cycle, 0x300C reads 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB5 completer: FSM states, error codes and a
// helper for deriving the byte-strobe width from the data width.
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic [3:0] ERR_OK    = 4'd0;
  localparam logic [3:0] ERR_RANGE = 4'd1;
  localparam logic [3:0] ERR_ALIGN = 4'd2;
  localparam logic [3:0] ERR_RO    = 4'd3;
  localparam logic [3:0] ERR_PROT  = 4'd4;

  function automatic int strbWidth(input int dataWidth);
    return dataWidth / 8;
  endfunction

endpackage

// File: rtl/apb_regbank_mem.sv
// Word storage for the register bank: each entry holds a data word plus a
// user word. Data is written per byte lane, the user word is replaced
// whenever any lane is written. Reads are asynchronous.
module apb_regbank_mem
  import apb_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 16,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int STRB_W    = strbWidth(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [STRB_W-1:0]     strb_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [USER_WIDTH-1:0] ruser_o
);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [USER_WIDTH-1:0] user_q [DEPTH];

  // Clear the whole bank on reset, otherwise apply a byte-enabled write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        user_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb_i[b]) data_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
      if (|strb_i) user_q[idx_i] <= wuser_i;
    end
  end

  assign rdata_o = data_q[idx_i];
  assign ruser_o = user_q[idx_i];

endmodule

// File: rtl/apb5_completer_regbank.sv
// APB5 completer with a small word-addressed register bank. The setup phase
// latches the request and classifies it; the access phase counts down the
// configured wait states and then completes with data or an error code.
module apb5_completer_regbank
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    USER_DATA_WIDTH = DATA_WIDTH / 2,
  parameter int                    USER_RESP_WIDTH = 16,
  parameter int                    DEPTH           = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 'h0000_3000,
  parameter int                    WAIT_CYCLES     = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE        = 'hA9B5_0001
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_WIDTH-1:0]      PADDR,
  input  logic [DATA_WIDTH-1:0]      PWDATA,
  input  logic [DATA_WIDTH/8-1:0]    PSTRB,
  input  logic [2:0]                 PPROT,
  input  logic [USER_DATA_WIDTH-1:0] PWUSER,
  output logic                       PREADY,
  output logic [DATA_WIDTH-1:0]      PRDATA,
  output logic                       PSLVERR,
  output logic [USER_DATA_WIDTH-1:0] PRUSER,
  output logic [USER_RESP_WIDTH-1:0] PBUSER
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = strbWidth(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] END_EXT  = BASE_EXT + (ADDR_WIDTH+1)'(4 * DEPTH);

  apb_state_e                 state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       write_q, write_d;
  logic [STRB_W-1:0]          strb_q, strb_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [USER_DATA_WIDTH-1:0] wuser_q, wuser_d;
  logic [3:0]                 err_q, err_d;

  logic                       inRange;
  logic [IDX_W-1:0]           setupIdx;
  logic [3:0]                 setupErr;
  logic [IDX_W-1:0]           idx;
  logic                       ready;
  logic                       commit;
  logic                       readOk;
  logic [DATA_WIDTH-1:0]      memRdata;
  logic [USER_DATA_WIDTH-1:0] memRuser;
  logic                       unusedProt;

  // Only the non-secure bit of PPROT influences the response.
  assign unusedProt = &{1'b0, PPROT[2], PPROT[0]};

  // Classify the request presented in the setup phase, highest priority first.
  always_comb begin
    inRange  = ({1'b0, PADDR} >= BASE_EXT) && ({1'b0, PADDR} < END_EXT);
    setupIdx = IDX_W'((PADDR - BASE_ADDR) >> 2);
    setupErr = ERR_OK;
    if (!inRange)                                     setupErr = ERR_RANGE;
    else if (PADDR[1:0] != 2'b00)                     setupErr = ERR_ALIGN;
    else if (PWRITE && (setupIdx == '0))              setupErr = ERR_RO;
    else if (PWRITE && PPROT[1] && setupIdx[IDX_W-1]) setupErr = ERR_PROT;
  end

  // Next-state logic: latch on setup, count wait states, leave on completion or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    wuser_d = wuser_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          strb_d  = PSTRB;
          wdata_d = PWDATA;
          wuser_d = PWUSER;
          err_d   = setupErr;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (cnt_q == 4'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer registers; reset abandons any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      wuser_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      wuser_q <= wuser_d;
      err_q   <= err_d;
    end
  end

  assign idx    = IDX_W'((addr_q - BASE_ADDR) >> 2);
  assign ready  = !PRESET && (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
  assign commit = ready && write_q && (err_q == ERR_OK);
  assign readOk = ready && !write_q && (err_q == ERR_OK);

  apb_regbank_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_DATA_WIDTH)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .we_i    (commit),
    .idx_i   (idx),
    .strb_i  (strb_q),
    .wdata_i (wdata_q),
    .wuser_i (wuser_q),
    .rdata_o (memRdata),
    .ruser_o (memRuser)
  );

  // Response outputs stay at zero unless the transfer is completing.
  always_comb begin
    PREADY  = ready;
    PSLVERR = ready && (err_q != ERR_OK);
    PBUSER  = ready ? USER_RESP_WIDTH'(err_q) : '0;
    PRDATA  = '0;
    PRUSER  = '0;
    if (readOk) begin
      PRDATA = (idx == '0) ? ID_VALUE : memRdata;
      PRUSER = memRuser;
    end
  end

endmodule
